// File: rtl/demux_pkt_scheduler.sv
// rtl/demux_pkt_scheduler.sv - round-robin packet sequencer for a 1-to-N demux
module demux_pkt_scheduler #(
    parameter int N_OUT   = 2,
    parameter int DW      = 8,
    parameter int PKT_LEN = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [DW-1:0]            in_data,
    output logic                     in_ready,
    input  logic [N_OUT-1:0]         en,
    output logic [N_OUT-1:0]         out_valid,
    output logic [DW-1:0]            out_data,
    input  logic [N_OUT-1:0]         out_ready,
    output logic [$clog2(N_OUT)-1:0] sel,
    output logic                     busy,
    output logic                     pkt_done,
    output logic                     timeout_err,
    input  logic                     err_clr
);
    localparam int SW = $clog2(N_OUT);
    localparam int BW = $clog2(PKT_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t        state;
    logic [SW-1:0] last;
    logic [BW-1:0] beat_cnt;
    logic [TW-1:0] stall_cnt;

    logic          grant_found;
    logic [SW-1:0] grant_idx;
    logic [SW-1:0] cand;
    logic          sel_ready;
    logic          handshake;
    logic          stalled;
    logic          last_beat;
    logic          err_set;

    assign out_data  = in_data;
    assign sel_ready = out_ready[sel];
    assign in_ready  = (state == SEND) && sel_ready;
    assign handshake = (state == SEND) && in_valid && sel_ready;
    assign stalled   = (state == SEND) && in_valid && !sel_ready;
    assign last_beat = (beat_cnt == BW'(PKT_LEN - 1));
    // Fires on the stall that brings the counter up to TIMEOUT.
    assign err_set   = stalled && (stall_cnt == TW'(TIMEOUT - 1));

    always_comb begin
        out_valid = '0;
        if (state == SEND) begin
            out_valid[sel] = in_valid;
        end
    end

    // Scan starts just after the previous grant so every enabled sink gets a turn.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = 1; i <= N_OUT; i++) begin
            cand = SW'((int'(last) + i) % N_OUT);
            if (!grant_found && en[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            sel         <= '0;
            last        <= SW'(N_OUT - 1);
            beat_cnt    <= '0;
            stall_cnt   <= '0;
            busy        <= 1'b0;
            pkt_done    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            pkt_done <= 1'b0;
            if (err_set) begin
                timeout_err <= 1'b1;
            end else if (err_clr) begin
                timeout_err <= 1'b0;
            end
            case (state)
                IDLE: begin
                    stall_cnt <= '0;
                    if (in_valid && grant_found) begin
                        sel      <= grant_idx;
                        last     <= grant_idx;
                        beat_cnt <= '0;
                        busy     <= 1'b1;
                        state    <= SEND;
                    end
                end
                SEND: begin
                    if (handshake) begin
                        stall_cnt <= '0;
                        if (last_beat) begin
                            beat_cnt <= '0;
                            busy     <= 1'b0;
                            pkt_done <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end else if (stalled) begin
                        if (stall_cnt != TW'(TIMEOUT)) begin
                            stall_cnt <= stall_cnt + 1'b1;
                        end
                    end else begin
                        stall_cnt <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
